capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Logic-analyzer capture controller; sits directly upstream of the 2Kx8 sample BRAM and owns its single port.
//  Armed by software, it streams probe samples into the BRAM as a circular buffer until a masked-pattern trigger.
//  It then records post_count further samples, freezes, and serves offset-addressed readback of the captured window.
// PARAMETERS
//  ADDR_W   11   BRAM address width; buffer depth = 2**ADDR_W (2048)
//  DATA_W   8    probe / sample width
// PORTS
//  CLK         in   1       system clock, all logic on posedge
//  RST_N       in   1       asynchronous, active-low reset
//  arm         in   1       1-cycle pulse: latch config, clear pointers, enter ARMED
//  sample_en   in   1       qualifies probe this cycle (sample-rate divider strobe)
//  probe       in   DATA_W  sampled input channels
//  trig_value  in   DATA_W  trigger pattern
//  trig_mask   in   DATA_W  1 = bit participates in trigger compare
//  post_count  in   ADDR_W  samples to record after trigger sample; latched on arm
//  rd_req      in   1       readback request (honoured in DONE only)
//  rd_offset   in   ADDR_W  readback index, 0 = oldest sample in window
//  rd_data     out  DATA_W  readback data
//  rd_valid    out  1       rd_data valid this cycle
//  state       out  2       IDLE=00 ARMED=01 POST=10 DONE=11
//  wrapped     out  1       buffer has filled at least once since arm
//  trig_pos    out  ADDR_W  index of trigger sample relative to oldest sample
//  bram_en     out  1       BRAM enable
//  bram_we     out  1       BRAM write enable
//  bram_addr   out  ADDR_W  BRAM address
//  bram_din    out  DATA_W  BRAM write data
//  bram_dout   in   DATA_W  BRAM read data (1-cycle registered latency, holds when EN=0)
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, wrapped=0, trig_addr=0, trig_pos=0, rd_valid=0, rd_data=0; BRAM contents untouched.
//  BRAM port driven combinationally from registered state + inputs:
//   - ARMED/POST and sample_en: bram_en=1, bram_we=1, bram_addr=wr_ptr, bram_din=probe.
//   - DONE and rd_req: bram_en=1, bram_we=0, bram_addr=(start+rd_offset) mod 2**ADDR_W.
//   - otherwise bram_en=bram_we=0, bram_addr=0, bram_din=0.
//  Each write: wr_ptr+1 mod 2**ADDR_W; 2047->0 sets wrapped (sticky until arm).
//  start = wrapped ? wr_ptr : 0 (wr_ptr frozen in DONE).
//  hit = sample_en & (((probe ^ trig_value) & trig_mask) == 0); trig_mask=0 -> first qualified sample hits.
//  FSM:
//   IDLE  -arm->  ARMED (wr_ptr=0, wrapped=0, post_count latched as remain).
//   ARMED -hit->  trigger sample written, trig_addr=wr_ptr; remain==0 ? DONE : POST.
//   POST  each qualified sample written, remain-1; the write that takes remain 1->0 also moves to DONE.
//   DONE  holds; trig_pos=(trig_addr-start) mod 2**ADDR_W, registered on DONE entry.
//  arm in any state (incl. ARMED/POST) restarts capture; arm has priority over hit and rd_req.
//  post_count max 2047 < depth, so trigger sample is never overwritten.
//  No trigger before wrap: window = [0, wr_ptr-1]; software uses wrapped/trig_pos to size it.
//  Readback: rd_valid=rd_req delayed 1 cycle (DONE only); rd_data=bram_dout when rd_valid, else holds.
//   Back-to-back rd_req gives one result per cycle, in order.
//  Async reset mid-capture -> IDLE immediately; partial capture abandoned.
// TESTING
//  1 Reset, arm, mask=FF value=3C, post_count=4, probe ramps 00.. every cycle -> trigger on 3C at addr 3C, DONE
//    after 5 writes (3C..40), trig_addr=03C, trig_pos=03C, wrapped=0.
//  2 Ramp probe 3000 cycles, trigger late, post_count=100 -> wrapped=1, start=wr_ptr, trig_pos=2047-100=1947;
//    readback offsets 0..2047 match probe history in order.
//  3 trig_mask=00, post_count=0 -> first sample triggers, DONE next cycle, trig_pos=0, exactly 1 BRAM write.
//  4 sample_en 1-in-4 -> writes only on strobe cycles; unqualified matching probe never triggers.
//  5 rd_req burst offsets 0..7 in DONE -> rd_valid 1 cycle later, 8 consecutive correct bytes;
//    rd_req in ARMED -> no BRAM read, rd_valid=0.
//  6 arm during POST restarts (wr_ptr=0, wrapped=0); RST_N low mid-POST -> state=00 same cycle, bram_we=0.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - single-port sample BRAM bus between capture controller and memory
interface capture_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output en, output we, output addr, output din, input dout);
  modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - logic-analyzer capture controller driving a circular sample BRAM
module capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] probe,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic              wrapped,
  output logic [ADDR_W-1:0] trig_pos,
  capture_ctrl_if.master    bram
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W-1:0] remain, remain_d;
  logic [ADDR_W-1:0] trig_addr, trig_addr_d;
  logic [ADDR_W-1:0] trig_pos_q;
  logic [ADDR_W-1:0] start, start_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_hold;
  logic              hit, wr_fire, rd_fire, done_entry;

  // Arm wins over any write or read issued in the same cycle.
  assign hit     = sample_en && (((probe ^ trig_value) & trig_mask) == '0);
  assign wr_fire = (state_q == S_ARMED || state_q == S_POST) && sample_en && !arm;
  assign rd_fire = (state_q == S_DONE) && rd_req && !arm;
  assign start   = wrapped_q ? wr_ptr : '0;

  // BRAM port: capture writes take the pointer, readback is offset from the oldest sample.
  always_comb begin
    bram.en   = wr_fire || rd_fire;
    bram.we   = wr_fire;
    bram.addr = '0;
    bram.din  = '0;
    if (wr_fire) begin
      bram.addr = wr_ptr;
      bram.din  = probe;
    end else if (rd_fire) begin
      bram.addr = start + rd_offset;
    end
  end

  // Next-state and pointer/counter updates.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr;
    wrapped_d   = wrapped_q;
    remain_d    = remain;
    trig_addr_d = trig_addr;
    if (arm) begin
      state_d   = S_ARMED;
      wr_ptr_d  = '0;
      wrapped_d = 1'b0;
      remain_d  = post_count;
    end else if (wr_fire) begin
      wr_ptr_d = wr_ptr + ONE;
      if (wr_ptr == '1) wrapped_d = 1'b1;
      if (state_q == S_ARMED) begin
        if (hit) begin
          trig_addr_d = wr_ptr;
          state_d     = (remain == '0) ? S_DONE : S_POST;
        end
      end else begin
        remain_d = remain - ONE;
        if (remain == ONE) state_d = S_DONE;
      end
    end
  end

  // Window start as it will stand once DONE is entered (pointer frozen from then on).
  assign start_d    = wrapped_d ? wr_ptr_d : '0;
  assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture datapath registers; trig_pos is resolved once on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      wrapped_q  <= 1'b0;
      remain     <= '0;
      trig_addr  <= '0;
      trig_pos_q <= '0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      remain    <= remain_d;
      trig_addr <= trig_addr_d;
      if (done_entry) trig_pos_q <= trig_addr_d - start_d;
    end
  end

  // Readback: valid tracks the BRAM's one-cycle read latency; last result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_valid_q) rd_hold <= bram.dout;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? bram.dout : rd_hold;
  assign state    = state_q;
  assign wrapped  = wrapped_q;
  assign trig_pos = trig_pos_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - directed scoreboard bench for capture_ctrl with a behavioural BRAM
module tb_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  probe = '0;
  logic [7:0]  trig_value = '0;
  logic [7:0]  trig_mask = '0;
  logic [10:0] post_count = '0;
  logic        rd_req = 1'b0;
  logic [10:0] rd_offset = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [1:0]  state;
  logic        wrapped;
  logic [10:0] trig_pos;

  capture_ctrl_if #(.ADDR_W(11), .DATA_W(8)) bus ();

  capture_ctrl #(.ADDR_W(11), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .sample_en(sample_en), .probe(probe),
    .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
    .rd_req(rd_req), .rd_offset(rd_offset), .rd_data(rd_data), .rd_valid(rd_valid),
    .state(state), .wrapped(wrapped), .trig_pos(trig_pos), .bram(bus.master)
  );

  always #5 clk = ~clk;

  // 2Kx8 BRAM model: registered read, output holds while disabled
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.we) mem[bus.addr] <= bus.din;
      bus.dout <= mem[bus.addr];
    end
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         wcount = 0;
  int         bad_w = 0;
  bit         tb_done = 1'b0;
  logic [7:0] hist[$];
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] win(input int o);
    int base;
    base = (hist.size() > 2048) ? hist.size() - 2048 : 0;
    return hist[base + o];
  endfunction

  task automatic step();
    logic exp_v;
    logic [7:0] e;
    exp_v = rd_req && tb_done && !arm;
    @(posedge clk); #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    if (rd_valid) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rd_data", {24'd0, rd_data}, {24'd0, e});
      end
    end
  endtask

  task automatic do_arm(input logic [7:0] m, input logic [7:0] v, input logic [10:0] pc);
    arm = 1'b1; trig_mask = m; trig_value = v; post_count = pc;
    sample_en = 1'b0; rd_req = 1'b0; tb_done = 1'b0;
    step();
    arm = 1'b0;
    hist.delete();
    wcount = 0;
    bad_w = 0;
  endtask

  task automatic sample(input logic en, input logic [7:0] p);
    sample_en = en; probe = p;
    #1;
    if (bus.we) wcount++;
    if (bus.we && !en) bad_w++;
    if (en) hist.push_back(p);
    step();
  endtask

  task automatic read_burst(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      rd_req = 1'b1;
      rd_offset = 11'(first + k);
      sb.push_back(win(first + k));
      step();
    end
    rd_req = 1'b0;
    step();
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int i;
    logic [7:0] p;

    // reset state
    #12;
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_wrapped", {31'd0, wrapped}, 0);
    chk("rst_trig_pos", {21'd0, trig_pos}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_bram_en", {31'd0, bus.en}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // 1: exact-match trigger on 3C, four post samples
    do_arm(8'hFF, 8'h3C, 11'd4);
    chk("t1_armed", {30'd0, state}, 1);
    i = 0;
    while (state != 2'b11 && i < 300) begin sample(1'b1, 8'(i)); i++; end
    chk("t1_done", {30'd0, state}, 3);
    chk("t1_writes", wcount, 65);
    chk("t1_trig_pos", {21'd0, trig_pos}, 32'h3C);
    chk("t1_wrapped", {31'd0, wrapped}, 0);
    sample_en = 1'b0;
    tb_done = 1'b1;
    read_burst(16'h3C, 5);

    // 2: late trigger after wrapping, 100 post samples, full readback
    do_arm(8'hFF, 8'hA5, 11'd100);
    i = 0;
    while (state != 2'b11 && i < 3200) begin
      p = 8'(i * 37 + 5);
      if (p == 8'hA5) p = 8'h00;
      if (i == 2900) p = 8'hA5;
      sample(1'b1, p);
      i++;
    end
    chk("t2_done", {30'd0, state}, 3);
    chk("t2_writes", wcount, 3001);
    chk("t2_wrapped", {31'd0, wrapped}, 1);
    chk("t2_trig_pos", {21'd0, trig_pos}, 1947);
    sample_en = 1'b0;
    tb_done = 1'b1;
    read_burst(0, 2048);

    // 3: mask 00, post 0 -> first qualified sample triggers
    do_arm(8'h00, 8'h00, 11'd0);
    chk("t3_wrapped_clr", {31'd0, wrapped}, 0);
    sample_en = 1'b1; probe = 8'h77;
    #1;
    chk("t3_addr0", {21'd0, bus.addr}, 0);
    sample(1'b1, 8'h77);
    chk("t3_done", {30'd0, state}, 3);
    sample(1'b1, 8'h78);
    hist.pop_back();
    chk("t3_writes", wcount, 1);
    chk("t3_trig_pos", {21'd0, trig_pos}, 0);
    sample_en = 1'b0;
    tb_done = 1'b1;
    read_burst(0, 1);

    // 4: 1-in-4 strobe; matching probe on unqualified cycles must not trigger
    do_arm(8'hFF, 8'h55, 11'd2);
    for (int c = 0; c < 20; c++) begin
      if (c % 4 == 0) sample(1'b1, 8'(8'h10 + c));
      else            sample(1'b0, 8'h55);
    end
    chk("t4_still_armed", {30'd0, state}, 1);
    chk("t4_pre_writes", wcount, 5);
    i = 0;
    while (state != 2'b11 && i < 40) begin
      if (i % 4 == 0) sample(1'b1, (i == 0) ? 8'h55 : 8'(8'h40 + i));
      else            sample(1'b0, 8'h55);
      i++;
    end
    chk("t4_done", {30'd0, state}, 3);
    chk("t4_writes", wcount, 8);
    chk("t4_no_unqual_write", bad_w, 0);
    chk("t4_trig_pos", {21'd0, trig_pos}, 5);
    sample_en = 1'b0;

    // 5: back-to-back readback, then rd_req while ARMED
    tb_done = 1'b1;
    read_burst(0, 8);
    do_arm(8'hFF, 8'hFF, 11'd3);
    rd_req = 1'b1; rd_offset = 11'd3;
    #1;
    chk("t5_armed_no_en", {31'd0, bus.en}, 0);
    step();
    rd_req = 1'b0;
    step();

    // 6: re-arm during POST, then async reset mid-POST
    do_arm(8'h00, 8'h00, 11'd50);
    for (int c = 0; c < 10; c++) sample(1'b1, 8'(c));
    chk("t6_post", {30'd0, state}, 2);
    do_arm(8'h00, 8'h00, 11'd50);
    chk("t6_rearmed", {30'd0, state}, 1);
    chk("t6_wrapped", {31'd0, wrapped}, 0);
    sample_en = 1'b1; probe = 8'h99;
    #1;
    chk("t6_ptr_reset", {21'd0, bus.addr}, 0);
    chk("t6_we", {31'd0, bus.we}, 1);
    for (int c = 0; c < 5; c++) sample(1'b1, 8'(8'h99 + c));
    chk("t6_post2", {30'd0, state}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", {30'd0, state}, 0);
    chk("t6_rst_we", {31'd0, bus.we}, 0);
    chk("t6_rst_en", {31'd0, bus.en}, 0);
    sample_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle", {30'd0, state}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
